// File: rtl/m_updown_counter.sv
// m_updown_counter: up/down counter with a programmable terminal count and an
// enable prescaler. It supports parallel load, wrap or saturate at the
// boundaries, a one-cycle terminal-count pulse and a sticky overflow flag.
module m_updown_counter #(
    parameter int unsigned          WIDTH    = 8,
    parameter longint unsigned      MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter int unsigned          PRESCALE = 1,
    parameter bit                   SATURATE = 1'b0
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_en,
    input  logic             w_up,
    input  logic             w_load,
    input  logic [WIDTH-1:0] w_ld_val,
    input  logic             w_clr_ovf,
    output logic [WIDTH-1:0] w_cnt,
    output logic             w_tick,
    output logic             w_tc,
    output logic             w_ovf
);

    // Prescaler width; a single bit is kept even when PRESCALE=1 so the
    // register always exists and simply stays at 0.
    localparam int unsigned      PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);

    logic [PW-1:0]    r_pre;
    logic             pre_last;
    logic             at_max;
    logic             at_min;
    logic             boundary;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;

    assign pre_last = (r_pre == PRE_LAST);
    assign w_tick   = w_en & pre_last & ~w_load & ~w_rst;
    assign at_max   = (w_cnt == MAX_V);
    assign at_min   = (w_cnt == '0);
    assign boundary = w_tick & (w_up ? at_max : at_min);
    assign load_val = (w_ld_val > MAX_V) ? MAX_V : w_ld_val;

    // Next count for a step. The range wraps at MAX rather than at the
    // natural width, and there is never a carry out of WIDTH bits.
    always_comb begin
        step_val = w_cnt;
        if (w_up) begin
            if (at_max) step_val = SATURATE ? MAX_V : '0;
            else        step_val = w_cnt + 1'b1;
        end else begin
            if (at_min) step_val = SATURATE ? '0 : MAX_V;
            else        step_val = w_cnt - 1'b1;
        end
    end

    // Prescaler: advances on enabled cycles and wraps after PRESCALE of them.
    // A load restarts it so the first step after a load is a full period away.
    always_ff @(posedge w_clk) begin
        if (w_rst)       r_pre <= '0;
        else if (w_load) r_pre <= '0;
        else if (w_en)   r_pre <= pre_last ? '0 : r_pre + 1'b1;
    end

    // Count register. The priority is reset, then load, then step, then hold.
    always_ff @(posedge w_clk) begin
        if (w_rst)       w_cnt <= '0;
        else if (w_load) w_cnt <= load_val;
        else if (w_tick) w_cnt <= step_val;
    end

    // Terminal-count pulse: high for the single cycle after a boundary step,
    // so it lines up with the wrapped or held count value.
    always_ff @(posedge w_clk) begin
        if (w_rst) w_tc <= 1'b0;
        else       w_tc <= boundary;
    end

    // Sticky overflow flag. A boundary step in the same cycle as a clear
    // wins, so no event is lost. A load leaves the flag alone.
    always_ff @(posedge w_clk) begin
        if (w_rst)          w_ovf <= 1'b0;
        else if (boundary)  w_ovf <= 1'b1;
        else if (w_clr_ovf) w_ovf <= 1'b0;
    end

endmodule

// File: tb/tb_m_updown_counter.sv
// Scoreboard bench for m_updown_counter. There are two instances:
//   d=0: WIDTH=4, MAX=9, PRESCALE=1, wrap
//   d=1: WIDTH=4, MAX=15, PRESCALE=3, saturate
// The stimulus pushes hand-computed expectations into a queue each cycle.
// A monitor pops each entry and checks w_tick for that cycle and then the
// registered outputs after the edge.
module tb_m_updown_counter;

    typedef struct {
        int         d;
        string      nm;
        logic       tick;
        logic [3:0] cnt;
        logic       tc;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst[2];
    logic       en[2];
    logic       up[2];
    logic       load[2];
    logic [3:0] ld_val[2];
    logic       clr[2];
    logic [3:0] cnt[2];
    logic       tick[2];
    logic       tc[2];
    logic       ovf[2];

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   busy     = 1'b0;

    always #5 clk = ~clk;

    m_updown_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(1'b0)) u_a (
        .w_clk(clk), .w_rst(rst[0]), .w_en(en[0]), .w_up(up[0]),
        .w_load(load[0]), .w_ld_val(ld_val[0]), .w_clr_ovf(clr[0]),
        .w_cnt(cnt[0]), .w_tick(tick[0]), .w_tc(tc[0]), .w_ovf(ovf[0])
    );

    m_updown_counter #(.WIDTH(4), .MAX(15), .PRESCALE(3), .SATURATE(1'b1)) u_b (
        .w_clk(clk), .w_rst(rst[1]), .w_en(en[1]), .w_up(up[1]),
        .w_load(load[1]), .w_ld_val(ld_val[1]), .w_clr_ovf(clr[1]),
        .w_cnt(cnt[1]), .w_tick(tick[1]), .w_tc(tc[1]), .w_ovf(ovf[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle on DUT d while the other DUT idles, and queue the
    // expected tick for this cycle plus the expected state after the edge.
    task automatic cyc(input int d, input string nm, input bit r, input bit l,
                       input logic [3:0] lv, input bit e, input bit u, input bit c,
                       input bit x_tick, input logic [3:0] x_cnt, input bit x_tc,
                       input bit x_ovf);
        exp_t t;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; load[i] = 1'b0; en[i] = 1'b0; clr[i] = 1'b0;
        end
        rst[d] = r; load[d] = l; ld_val[d] = lv; en[d] = e; up[d] = u; clr[d] = c;
        t.d = d; t.nm = nm; t.tick = x_tick; t.cnt = x_cnt; t.tc = x_tc; t.ovf = x_ovf;
        q.push_back(t);
    endtask

    // Monitor: checks tick mid-cycle, then the registered outputs after the edge.
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                busy = 1'b1;
                r = q.pop_front();
                chk({r.nm, ".tick"}, 32'(tick[r.d]), 32'(r.tick));
                @(posedge clk);
                #1;
                chk({r.nm, ".cnt"}, 32'(cnt[r.d]), 32'(r.cnt));
                chk({r.nm, ".tc"},  32'(tc[r.d]),  32'(r.tc));
                chk({r.nm, ".ovf"}, 32'(ovf[r.d]), 32'(r.ovf));
                busy = 1'b0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; up[i] = 1'b1; load[i] = 1'b0;
            ld_val[i] = 4'd0; clr[i] = 1'b0;
        end
        //        d  name        rst ld lv  en up clr  tick cnt tc ovf
        // DUT A: MAX=9, wrap, no prescale
        cyc(0, "a_reset",    1, 0, 0,  1, 1, 0,   0, 0, 0, 0);
        cyc(0, "a_load2",    0, 1, 2,  1, 0, 0,   0, 2, 0, 0);
        cyc(0, "a_dn1",      0, 0, 0,  1, 0, 0,   1, 1, 0, 0);
        cyc(0, "a_dn0",      0, 0, 0,  1, 0, 0,   1, 0, 0, 0);
        cyc(0, "a_wrap9",    0, 0, 0,  1, 0, 0,   1, 9, 1, 1);
        cyc(0, "a_dn8",      0, 0, 0,  1, 0, 0,   1, 8, 0, 1);
        cyc(0, "a_up9",      0, 0, 0,  1, 1, 0,   1, 9, 0, 1);
        cyc(0, "a_wrap0",    0, 0, 0,  1, 1, 0,   1, 0, 1, 1);
        cyc(0, "a_up1",      0, 0, 0,  1, 1, 0,   1, 1, 0, 1);
        cyc(0, "a_hold",     0, 0, 0,  0, 1, 0,   0, 1, 0, 1);
        cyc(0, "a_ldclamp",  0, 1, 12, 1, 1, 0,   0, 9, 0, 1);
        cyc(0, "a_clrset",   0, 0, 0,  1, 1, 1,   1, 0, 1, 1);
        cyc(0, "a_clr",      0, 0, 0,  0, 1, 1,   0, 0, 0, 0);
        cyc(0, "a_load5",    0, 1, 5,  0, 1, 0,   0, 5, 0, 0);
        cyc(0, "a_tovf",     0, 1, 0,  1, 0, 0,   0, 0, 0, 0);
        cyc(0, "a_set_ovf",  0, 0, 0,  1, 0, 0,   1, 9, 1, 1);
        cyc(0, "a_dn8b",     0, 0, 0,  1, 0, 0,   1, 8, 0, 1);
        cyc(0, "a_ld5b",     0, 1, 5,  0, 1, 0,   0, 5, 0, 1);
        cyc(0, "a_rst_mid",  1, 0, 0,  1, 1, 0,   0, 0, 0, 0);
        cyc(0, "a_idle",     0, 0, 0,  0, 1, 0,   0, 0, 0, 0);
        cyc(0, "a_resume",   0, 0, 0,  1, 1, 0,   1, 1, 0, 0);
        cyc(0, "a_rst_ld",   1, 1, 12, 1, 1, 0,   0, 0, 0, 0);
        // DUT B: MAX=15, saturate, prescale 3
        cyc(1, "b_reset",    1, 0, 0,  1, 1, 0,   0, 0, 0, 0);
        cyc(1, "b_load14",   0, 1, 14, 1, 1, 0,   0, 14, 0, 0);
        cyc(1, "b_pre0",     0, 0, 0,  1, 1, 0,   0, 14, 0, 0);
        cyc(1, "b_pre1",     0, 0, 0,  1, 1, 0,   0, 14, 0, 0);
        cyc(1, "b_step15",   0, 0, 0,  1, 1, 0,   1, 15, 0, 0);
        cyc(1, "b_pre0b",    0, 0, 0,  1, 1, 0,   0, 15, 0, 0);
        cyc(1, "b_pre1b",    0, 0, 0,  1, 1, 0,   0, 15, 0, 0);
        cyc(1, "b_sat1",     0, 0, 0,  1, 1, 0,   1, 15, 1, 1);
        cyc(1, "b_pre0c",    0, 0, 0,  1, 1, 0,   0, 15, 0, 1);
        cyc(1, "b_gap1",     0, 0, 0,  0, 1, 0,   0, 15, 0, 1);
        cyc(1, "b_gap2",     0, 0, 0,  0, 1, 0,   0, 15, 0, 1);
        cyc(1, "b_pre1c",    0, 0, 0,  1, 1, 0,   0, 15, 0, 1);
        cyc(1, "b_sat2",     0, 0, 0,  1, 1, 0,   1, 15, 1, 1);
        cyc(1, "b_clr",      0, 0, 0,  0, 1, 1,   0, 15, 0, 0);
        cyc(1, "b_dn_p0",    0, 0, 0,  1, 0, 0,   0, 15, 0, 0);
        cyc(1, "b_dn_p1",    0, 0, 0,  1, 0, 0,   0, 15, 0, 0);
        cyc(1, "b_dn14",     0, 0, 0,  1, 0, 0,   1, 14, 0, 0);
        cyc(1, "b_mid_p0",   0, 0, 0,  1, 0, 0,   0, 14, 0, 0);
        cyc(1, "b_mid_ld3",  0, 1, 3,  1, 0, 0,   0, 3, 0, 0);
        cyc(1, "b_ld_p0",    0, 0, 0,  1, 0, 0,   0, 3, 0, 0);
        cyc(1, "b_ld_p1",    0, 0, 0,  1, 0, 0,   0, 3, 0, 0);
        cyc(1, "b_dn2",      0, 0, 0,  1, 0, 0,   1, 2, 0, 0);
        cyc(1, "b_ld0",      0, 1, 0,  0, 0, 0,   0, 0, 0, 0);
        cyc(1, "b_z_p0",     0, 0, 0,  1, 0, 0,   0, 0, 0, 0);
        cyc(1, "b_z_p1",     0, 0, 0,  1, 0, 0,   0, 0, 0, 0);
        cyc(1, "b_sat0",     0, 0, 0,  1, 0, 0,   1, 0, 1, 1);
        cyc(1, "b_r_p0",     0, 0, 0,  1, 1, 0,   0, 0, 0, 1);
        cyc(1, "b_rst_mid",  1, 0, 0,  1, 1, 0,   0, 0, 0, 0);
        cyc(1, "b_rs_p0",    0, 0, 0,  1, 1, 0,   0, 0, 0, 0);
        cyc(1, "b_rs_p1",    0, 0, 0,  1, 1, 0,   0, 0, 0, 0);
        cyc(1, "b_rs_up1",   0, 0, 0,  1, 1, 0,   1, 1, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; load[i] = 1'b0; en[i] = 1'b0; clr[i] = 1'b0;
        end
        // Wait a bounded time for the monitor to drain the scoreboard.
        for (int k = 0; k < 20 && (q.size() > 0 || busy); k++) @(negedge clk);
        #3;
        if (q.size() > 0 || busy) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
